decode_ctrl_queue: RTL

//  Registered RV32I instruction decoder with an output queue. Sits between fetch and execute.

---
 rtl/decode_ctrl_queue_if.sv | 45 ++++
 rtl/decode_ctrl_queue.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_ctrl_queue_if.sv
// Fetch-side and execute-side handshake bundle for decode_ctrl_queue.
// slave = decoder view, master = fetch/execute (or bench) view.
interface decode_ctrl_queue_if #(
  parameter int XLEN   = 32,
  parameter int ALUC_W = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_instr;
  logic [XLEN-1:0]   in_pc;

  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   out_pc;
  logic [4:0]        out_rd;
  logic [4:0]        out_rs1;
  logic [4:0]        out_rs2;
  logic              out_reg_write;
  logic              out_alu_src1;
  logic              out_alu_src2;
  logic [1:0]        out_result_src;
  logic [1:0]        out_mem_write;
  logic [2:0]        out_mem_read;
  logic [2:0]        out_br_type;
  logic              out_dmem_wr_en;
  logic              out_dmem_rd_en;
  logic [ALUC_W-1:0] out_alu_ctrl;
  logic              out_illegal;

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_rd, out_rs1, out_rs2,
           out_reg_write, out_alu_src1, out_alu_src2, out_result_src,
           out_mem_write, out_mem_read, out_br_type, out_dmem_wr_en,
           out_dmem_rd_en, out_alu_ctrl, out_illegal
  );

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_rd, out_rs1, out_rs2,
           out_reg_write, out_alu_src1, out_alu_src2, out_result_src,
           out_mem_write, out_mem_read, out_br_type, out_dmem_wr_en,
           out_dmem_rd_en, out_alu_ctrl, out_illegal
  );
endinterface

// File: rtl/decode_ctrl_queue.sv
// RV32I decoder feeding a DEPTH-entry control-bundle FIFO with flush and illegal counting.
// Define DECODE_MEXT_EN to accept RV32M (funct7=0000001) R-type encodings.
module decode_ctrl_queue #(
  parameter int XLEN   = 32,
  parameter int DEPTH  = 2,
  parameter int ALUC_W = 5,
  parameter int CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  decode_ctrl_queue_if.slave   bus,
  output logic [CNT_W-1:0]     illegal_cnt
);

  localparam int PTR_W = $clog2(DEPTH);

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;

  localparam logic [ALUC_W-1:0] ALU_ADD  = ALUC_W'(0);
  localparam logic [ALUC_W-1:0] ALU_SUB  = ALUC_W'(1);
  localparam logic [ALUC_W-1:0] ALU_AND  = ALUC_W'(2);
  localparam logic [ALUC_W-1:0] ALU_OR   = ALUC_W'(3);
  localparam logic [ALUC_W-1:0] ALU_PASS = ALUC_W'(4);
  localparam logic [ALUC_W-1:0] ALU_SLT  = ALUC_W'(5);
  localparam logic [ALUC_W-1:0] ALU_XOR  = ALUC_W'(6);
  localparam logic [ALUC_W-1:0] ALU_SRL  = ALUC_W'(7);
  localparam logic [ALUC_W-1:0] ALU_SLL  = ALUC_W'(8);
  localparam logic [ALUC_W-1:0] ALU_SRA  = ALUC_W'(9);
  localparam logic [ALUC_W-1:0] ALU_SLTU = ALUC_W'(10);

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic              reg_write;
    logic              alu_src1;
    logic              alu_src2;
    logic [1:0]        result_src;
    logic [1:0]        mem_write;
    logic [2:0]        mem_read;
    logic [2:0]        br_type;
    logic              dmem_wr_en;
    logic              dmem_rd_en;
    logic [ALUC_W-1:0] alu_ctrl;
    logic              illegal;
  } entry_t;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_PART  = 2'd1,
    S_FULL  = 2'd2
  } occ_e;

  occ_e              occ_q, occ_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  entry_t            mem_q [DEPTH];
  entry_t            dec;
  entry_t            head;
  logic              legal;
  logic              push;
  logic              pop;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = bus.in_instr[6:0];
  assign funct3 = bus.in_instr[14:12];
  assign funct7 = bus.in_instr[31:25];

  // ---------------------------------------------------------------- decode
  always_comb begin
    dec   = '0;
    legal = 1'b1;
    case (opcode)
      OPC_R: begin
        dec.reg_write = 1'b1;
        if (funct7 == 7'b0000000) begin
          case (funct3)
            3'b000: dec.alu_ctrl = ALU_ADD;
            3'b001: dec.alu_ctrl = ALU_SLL;
            3'b010: dec.alu_ctrl = ALU_SLT;
            3'b011: dec.alu_ctrl = ALU_SLTU;
            3'b100: dec.alu_ctrl = ALU_XOR;
            3'b101: dec.alu_ctrl = ALU_SRL;
            3'b110: dec.alu_ctrl = ALU_OR;
            default: dec.alu_ctrl = ALU_AND;
          endcase
        end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
          dec.alu_ctrl = ALU_SUB;
        end else if (funct7 == 7'b0100000 && funct3 == 3'b101) begin
          dec.alu_ctrl = ALU_SRA;
`ifdef DECODE_MEXT_EN
        end else if (funct7 == 7'b0000001) begin
          // mul..remu occupy codes 16..23 so they never alias the base ALU ops
          dec.alu_ctrl = ALUC_W'(16) + ALUC_W'(funct3);
`endif
        end else begin
          legal = 1'b0;
        end
      end
      OPC_I: begin
        dec.reg_write = 1'b1;
        dec.alu_src2  = 1'b1;
        case (funct3)
          3'b000: dec.alu_ctrl = ALU_ADD;
          3'b001: begin
            dec.alu_ctrl = ALU_SLL;
            legal        = (funct7 == 7'b0000000);
          end
          3'b010: dec.alu_ctrl = ALU_SLT;
          3'b011: dec.alu_ctrl = ALU_SLTU;
          3'b100: dec.alu_ctrl = ALU_XOR;
          3'b101: begin
            dec.alu_ctrl = (funct7 == 7'b0100000) ? ALU_SRA : ALU_SRL;
            legal        = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
          end
          3'b110: dec.alu_ctrl = ALU_OR;
          default: dec.alu_ctrl = ALU_AND;
        endcase
      end
      OPC_BRANCH: begin
        dec.alu_ctrl = ALU_SUB;
        case (funct3)
          3'b000: dec.br_type = 3'b001;
          3'b001: dec.br_type = 3'b010;
          3'b100: dec.br_type = 3'b101;
          3'b101: dec.br_type = 3'b110;
          3'b110: dec.br_type = 3'b011;
          3'b111: dec.br_type = 3'b100;
          default: legal = 1'b0;
        endcase
      end
      OPC_LUI: begin
        dec.reg_write = 1'b1;
        dec.alu_src2  = 1'b1;
        dec.alu_ctrl  = ALU_PASS;
      end
      OPC_AUIPC: begin
        dec.reg_write = 1'b1;
        dec.alu_src1  = 1'b1;
        dec.alu_src2  = 1'b1;
        dec.alu_ctrl  = ALU_ADD;
      end
      OPC_JAL: begin
        dec.reg_write  = 1'b1;
        dec.alu_src1   = 1'b1;
        dec.alu_src2   = 1'b1;
        dec.result_src = 2'b10;
        dec.br_type    = 3'b111;
      end
      OPC_JALR: begin
        dec.reg_write  = 1'b1;
        dec.alu_src2   = 1'b1;
        dec.result_src = 2'b10;
        dec.br_type    = 3'b111;
      end
      OPC_LOAD: begin
        dec.reg_write  = 1'b1;
        dec.alu_src2   = 1'b1;
        dec.result_src = 2'b01;
        dec.dmem_rd_en = 1'b1;
        case (funct3)
          3'b000: dec.mem_read = 3'b001;
          3'b001: dec.mem_read = 3'b010;
          3'b010: dec.mem_read = 3'b000;
          3'b100: dec.mem_read = 3'b011;
          3'b101: dec.mem_read = 3'b100;
          default: legal = 1'b0;
        endcase
      end
      OPC_STORE: begin
        dec.alu_src2   = 1'b1;
        dec.dmem_wr_en = 1'b1;
        case (funct3)
          3'b000: dec.mem_write = 2'b01;
          3'b001: dec.mem_write = 2'b10;
          3'b010: dec.mem_write = 2'b11;
          default: legal = 1'b0;
        endcase
      end
      OPC_FENCE: ;
      default: legal = 1'b0;
    endcase

    // Illegal words still carry their pc and register fields for the trap handler
    if (!legal) begin
      dec         = '0;
      dec.illegal = 1'b1;
    end
    dec.pc  = bus.in_pc;
    dec.rd  = bus.in_instr[11:7];
    dec.rs1 = bus.in_instr[19:15];
    dec.rs2 = bus.in_instr[24:20];
    if (dec.rd == 5'd0) begin
      dec.reg_write = 1'b0;
    end
  end

  // ---------------------------------------------------------------- queue control
  assign bus.in_ready  = (occ_q != S_FULL);
  assign bus.out_valid = (occ_q != S_EMPTY);
  assign push = bus.in_valid && bus.in_ready;
  assign pop  = bus.out_valid && bus.out_ready;

  always_comb begin
    occ_d    = occ_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      occ_d    = S_EMPTY;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (push && dec.illegal && (cnt_q != '1)) begin
        cnt_d = cnt_q + 1'b1;
      end
      case (occ_q)
        S_EMPTY: if (push) occ_d = S_PART;
        S_PART: begin
          if (push && !pop && (wr_ptr_d == rd_ptr_q)) begin
            occ_d = S_FULL;
          end else if (pop && !push && (rd_ptr_d == wr_ptr_q)) begin
            occ_d = S_EMPTY;
          end
        end
        S_FULL:  if (pop) occ_d = S_PART;
        default: occ_d = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q    <= S_EMPTY;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      occ_q    <= occ_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the queue is empty
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_q[wr_ptr_q] <= dec;
    end
  end

  always_comb begin
    head = '0;
    if (bus.out_valid) begin
      head = mem_q[rd_ptr_q];
    end
  end

  assign bus.out_pc         = head.pc;
  assign bus.out_rd         = head.rd;
  assign bus.out_rs1        = head.rs1;
  assign bus.out_rs2        = head.rs2;
  assign bus.out_reg_write  = head.reg_write;
  assign bus.out_alu_src1   = head.alu_src1;
  assign bus.out_alu_src2   = head.alu_src2;
  assign bus.out_result_src = head.result_src;
  assign bus.out_mem_write  = head.mem_write;
  assign bus.out_mem_read   = head.mem_read;
  assign bus.out_br_type    = head.br_type;
  assign bus.out_dmem_wr_en = head.dmem_wr_en;
  assign bus.out_dmem_rd_en = head.dmem_rd_en;
  assign bus.out_alu_ctrl   = head.alu_ctrl;
  assign bus.out_illegal    = head.illegal;
  assign illegal_cnt        = cnt_q;

endmodule
